// File: rtl/svc_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : svc_axil_pkg
// Description : Shared AXI-Lite definitions for the read and write arbiters.
//               Holds the AXI response encodings and the arbiter state type.
// Revision    : 1.0 - initial release
// ============================================================================
package svc_axil_pkg;

  // AXI response encodings. These pass through the arbiters untouched.
  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;
  localparam logic [1:0] C_RESP_DECERR = 2'b11;

  // Arbiter transaction phases: waiting for a request, address presented
  // downstream, waiting for the response beat.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } axil_state_e;

endpackage
`default_nettype wire

// File: rtl/svc_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : svc_rr_pick
// Description : Combinational round-robin picker. Returns the first asserted
//               request at or above i_rr_ptr, wrapping modulo NUM_M.
// Ports       : i_req     - request vector, one bit per manager
//               i_rr_ptr  - index with the highest priority this round
//               o_winner  - index of the selected request
//               o_valid   - at least one request is asserted
// Revision    : 1.0 - initial release
// ============================================================================
module svc_rr_pick #(
  parameter int NUM_M   = 2,
  parameter int GRANT_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic [NUM_M-1:0]   i_req,
  input  logic [GRANT_W-1:0] i_rr_ptr,
  output logic [GRANT_W-1:0] o_winner,
  output logic               o_valid
);

  logic [2*NUM_M-1:0] req_dbl;
  logic [NUM_M-1:0]   req_rot;
  int                 pos;
  int                 sum;

  always_comb begin
    // Rotate so that bit 0 of req_rot is the manager at i_rr_ptr; the lowest
    // set bit of req_rot is then the offset of the winner from the pointer.
    req_dbl  = {i_req, i_req} >> i_rr_ptr;
    req_rot  = req_dbl[NUM_M-1:0];
    pos      = 0;
    o_valid  = 1'b0;
    // Descending scan: the last hit (smallest offset) wins.
    for (int off = NUM_M - 1; off >= 0; off--) begin
      if (req_rot[off]) begin
        pos     = off;
        o_valid = 1'b1;
      end
    end
    sum = int'(i_rr_ptr) + pos;
    if (sum >= NUM_M) begin
      sum = sum - NUM_M;
    end
    o_winner = GRANT_W'(sum);
  end

endmodule
`default_nettype wire

// File: rtl/svc_axil_arbiter_rd.sv
`default_nettype none
// ============================================================================
// Module      : svc_axil_arbiter_rd
// Description : AXI-Lite read-channel arbiter. Merges NUM_M upstream read
//               managers onto one downstream read port, one transaction in
//               flight, round-robin fairness between managers.
// Ports       : clk, rst          - clock, async active-high reset
//               s_axil_ar*        - per-manager read address channels
//               s_axil_r*         - per-manager read data channels
//               m_axil_ar*        - downstream read address (registered)
//               m_axil_r*         - downstream read data (combinational path)
// Revision    : 1.0 - initial release
// ============================================================================
module svc_axil_arbiter_rd
  import svc_axil_pkg::*;
#(
  parameter int NUM_M           = 2,
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_M-1:0]                 s_axil_arvalid,
  input  logic [NUM_M*AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
  output logic [NUM_M-1:0]                 s_axil_arready,
  output logic [NUM_M-1:0]                 s_axil_rvalid,
  output logic [NUM_M*AXIL_DATA_WIDTH-1:0] s_axil_rdata,
  output logic [NUM_M*2-1:0]               s_axil_rresp,
  input  logic [NUM_M-1:0]                 s_axil_rready,
  output logic                             m_axil_arvalid,
  output logic [AXIL_ADDR_WIDTH-1:0]       m_axil_araddr,
  input  logic                             m_axil_arready,
  input  logic                             m_axil_rvalid,
  input  logic [AXIL_DATA_WIDTH-1:0]       m_axil_rdata,
  input  logic [1:0]                       m_axil_rresp,
  output logic                             m_axil_rready
);

  localparam int GRANT_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  axil_state_e                state_q, state_d;
  logic [GRANT_W-1:0]         grant_q, grant_d;
  logic [GRANT_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic                       arvalid_q, arvalid_d;
  logic [AXIL_ADDR_WIDTH-1:0] araddr_q, araddr_d;

  logic [GRANT_W-1:0]         pick_idx;
  logic                       pick_valid;
  logic [GRANT_W-1:0]         grant_inc;

  svc_rr_pick #(
    .NUM_M   (NUM_M),
    .GRANT_W (GRANT_W)
  ) u_pick (
    .i_req    (s_axil_arvalid),
    .i_rr_ptr (rr_ptr_q),
    .o_winner (pick_idx),
    .o_valid  (pick_valid)
  );

  // Next round starts just past the manager that was served. With NUM_M = 1
  // this always yields 0, so the pointer never moves.
  assign grant_inc = (int'(grant_q) == NUM_M - 1) ? '0 : grant_q + GRANT_W'(1);

  // Response data and status fan out to every lane; only rvalid is steered.
  assign s_axil_rdata   = {NUM_M{m_axil_rdata}};
  assign s_axil_rresp   = {NUM_M{m_axil_rresp}};
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_araddr  = araddr_q;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_ptr_d       = rr_ptr_q;
    arvalid_d      = arvalid_q;
    araddr_d       = araddr_q;
    s_axil_arready = '0;
    s_axil_rvalid  = '0;
    m_axil_rready  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Reset is checked here so no arready leaks out while rst is held.
        if (pick_valid && !rst) begin
          s_axil_arready[pick_idx] = 1'b1;
          grant_d   = pick_idx;
          araddr_d  = s_axil_araddr[int'(pick_idx)*AXIL_ADDR_WIDTH +: AXIL_ADDR_WIDTH];
          arvalid_d = 1'b1;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (arvalid_q && m_axil_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        s_axil_rvalid[grant_q] = m_axil_rvalid;
        m_axil_rready          = s_axil_rready[grant_q];
        if (m_axil_rvalid && s_axil_rready[grant_q]) begin
          rr_ptr_d = grant_inc;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
    end
  end

endmodule
`default_nettype wire
